// File: rtl/softmax_job_sched_pkg.sv
// Shared constants for the softmax job scheduler.
// FSM encodings and default widths.
package softmax_job_sched_pkg;

  localparam int ADDRSIZE  = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAGW  = 4;
  localparam int DEF_CNTW  = 16;
  localparam int DEF_TMO   = 1024;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_BUSY  = 3'd4;
  localparam logic [2:0] S_CPL   = 3'd5;

endpackage

// File: rtl/softmax_job_sched_desc_fifo.sv
// Descriptor FIFO: sync, extra pointer bit for full/empty, flush.
// Ports: clk, reset(active-low sync), flush, push/wdata, pop/rdata, full, empty.
module softmax_job_sched_desc_fifo
  import softmax_job_sched_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/softmax_job_sched.sv
// Job scheduler sequencing softmax init/start/done per descriptor.
// Ports: desc_* in, sm_* to/from core, cpl_* out, busy, jobs_done.
// Option: SOFTMAX_SCHED_TIMEOUT_EN adds a BUSY watchdog of TMO cycles.
module softmax_job_sched
  import softmax_job_sched_pkg::*;
#(
  parameter int ADDRW = ADDRSIZE,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAGW  = DEF_TAGW,
  parameter int CNTW  = DEF_CNTW,
  parameter int TMO   = DEF_TMO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [ADDRW-1:0] desc_start,
  input  logic [ADDRW-1:0] desc_end,
  input  logic [TAGW-1:0]  desc_tag,
  input  logic             flush,
  output logic             sm_init,
  output logic             sm_start,
  output logic [ADDRW-1:0] sm_start_addr,
  output logic [ADDRW-1:0] sm_end_addr,
  input  logic             sm_done,
  output logic             cpl_valid,
  output logic [TAGW-1:0]  cpl_tag,
  output logic             cpl_err,
  output logic             busy,
  output logic [CNTW-1:0]  jobs_done
);

  localparam int DW = 2 * ADDRW + TAGW;

  logic [2:0]       state;
  logic [ADDRW-1:0] job_start;
  logic [ADDRW-1:0] job_end;
  logic [TAGW-1:0]  job_tag;
  logic             job_err;
  logic             done_q;
  logic             done_rise;
  logic             tmo_hit;

  logic [DW-1:0]    f_wdata;
  logic [DW-1:0]    f_rdata;
  logic             f_full;
  logic             f_empty;
  logic             f_pop;

  assign f_wdata = {desc_start, desc_end, desc_tag};
  assign f_pop   = (state == S_IDLE) && !f_empty;

  softmax_job_sched_desc_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (desc_valid),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  // Only a fresh 0->1 transition counts; a level left high
  // by the previous job is ignored.
  assign done_rise = sm_done && !done_q;

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == S_BUSY) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == S_BUSY) &&
                   (tmo_cnt == TW'(TMO - 1));
`else
  // No watchdog: BUSY waits for the core indefinitely.
  assign tmo_hit = 1'b0 && (TMO != 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      job_start <= '0;
      job_end   <= '0;
      job_tag   <= '0;
      job_err   <= 1'b0;
      done_q    <= 1'b0;
      jobs_done <= '0;
    end else begin
      done_q <= sm_done;
      unique case (state)
        S_IDLE: begin
          if (!f_empty) begin
            {job_start, job_end, job_tag} <= f_rdata;
            job_err <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (job_end < job_start) begin
            job_err <= 1'b1;
            state   <= S_CPL;
          end else begin
            state <= S_INIT;
          end
        end
        S_INIT:  state <= S_START;
        S_START: state <= S_BUSY;
        S_BUSY: begin
          if (done_rise) begin
            state <= S_CPL;
          end else if (tmo_hit) begin
            job_err <= 1'b1;
            state   <= S_CPL;
          end
        end
        S_CPL: begin
          if (!job_err) jobs_done <= jobs_done + CNTW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign desc_ready    = !f_full;
  assign sm_init       = (state == S_INIT);
  assign sm_start      = (state == S_START);
  assign sm_start_addr = job_start;
  assign sm_end_addr   = job_end;
  assign cpl_valid     = (state == S_CPL);
  assign cpl_tag       = cpl_valid ? job_tag : '0;
  assign cpl_err       = cpl_valid && job_err;
  assign busy          = (state != S_IDLE) || !f_empty;

endmodule

// File: tb/tb_softmax_job_sched.sv
// Scoreboard bench for softmax_job_sched with a small core model.
// Stimulus pushes expected completions; a monitor pops and compares.
module tb_softmax_job_sched;

  localparam int ADDRW = 8;
  localparam int TAGW  = 4;
  localparam int CNTW  = 3;
  localparam int TMO   = 40;

  logic             clk;
  logic             reset;
  logic             desc_valid;
  logic             desc_ready;
  logic [ADDRW-1:0] desc_start;
  logic [ADDRW-1:0] desc_end;
  logic [TAGW-1:0]  desc_tag;
  logic             flush;
  logic             sm_init;
  logic             sm_start;
  logic [ADDRW-1:0] sm_start_addr;
  logic [ADDRW-1:0] sm_end_addr;
  logic             sm_done;
  logic             cpl_valid;
  logic [TAGW-1:0]  cpl_tag;
  logic             cpl_err;
  logic             busy;
  logic [CNTW-1:0]  jobs_done;

  softmax_job_sched #(
    .ADDRW (ADDRW),
    .DEPTH (4),
    .TAGW  (TAGW),
    .CNTW  (CNTW),
    .TMO   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_start    (desc_start),
    .desc_end      (desc_end),
    .desc_tag      (desc_tag),
    .flush         (flush),
    .sm_init       (sm_init),
    .sm_start      (sm_start),
    .sm_start_addr (sm_start_addr),
    .sm_end_addr   (sm_end_addr),
    .sm_done       (sm_done),
    .cpl_valid     (cpl_valid),
    .cpl_tag       (cpl_tag),
    .cpl_err       (cpl_err),
    .busy          (busy),
    .jobs_done     (jobs_done)
  );

  typedef struct {
    logic [ADDRW-1:0] s;
    logic [ADDRW-1:0] e;
    logic [TAGW-1:0]  tag;
    logic             err;
    int               ninit;
  } exp_t;

  exp_t sbq[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int cpl_cnt = 0;
  int last_cpl_cyc = 0;
  int core_lat = 20;
  int core_mode = 0;
  logic man_done = 1'b0;
  logic gap_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench watchdog expired");
  end

  // Core model: mode 0 raises done core_lat cycles after start
  // and clears it on init; mode 1 follows man_done; mode 2
  // never completes.
  initial begin
    int ccnt;
    ccnt = 0;
    sm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sm_done = 1'b0;
        ccnt = 0;
      end else if (core_mode == 1) begin
        sm_done = man_done;
      end else begin
        if (sm_init) sm_done = 1'b0;
        if (core_mode == 0) begin
          if (sm_start) begin
            ccnt = core_lat;
          end else if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) sm_done = 1'b1;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    int init_c;
    int start_c;
    bit chk_jd;
    bit gap_ok;
    logic [CNTW-1:0] exp_jd;
    exp_t h;
    init_c = 0;
    start_c = 0;
    chk_jd = 0;
    gap_ok = 0;
    exp_jd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        init_c = 0;
        start_c = 0;
        chk_jd = 0;
        gap_ok = 0;
        exp_jd = '0;
      end else begin
        if (!gap_en) gap_ok = 0;
        if (chk_jd) chk("jobs_done", 32'(jobs_done), 32'(exp_jd));
        chk_jd = 0;
        if (sm_init) begin
          init_c++;
          if (gap_ok) chk("b2b_gap", cyc - last_cpl_cyc, 3);
        end
        if (sm_start) start_c++;
        if ((sm_init || sm_start) && sbq.size() > 0) begin
          h = sbq[0];
          chk("run_addr", {sm_start_addr, sm_end_addr}, {h.s, h.e});
        end
        if (cpl_valid) begin
          cpl_cnt++;
          last_cpl_cyc = cyc;
          gap_ok = gap_en;
          if (sbq.size() == 0) begin
            n_tot++;
            $display("FAIL cpl_unexpected: got tag %0d want none",
                     cpl_tag);
          end else begin
            h = sbq.pop_front();
            chk("cpl_tag", 32'(cpl_tag), 32'(h.tag));
            chk("cpl_err", 32'(cpl_err), 32'(h.err));
            chk("cpl_addr", {sm_start_addr, sm_end_addr}, {h.s, h.e});
            chk("init_pulses", init_c, h.ninit);
            chk("start_pulses", start_c, h.ninit);
            if (!h.err) exp_jd = exp_jd + 1'b1;
            chk_jd = 1;
          end
          init_c = 0;
          start_c = 0;
        end
      end
    end
  end

  task automatic push(input int s, input int e, input int t,
                      input bit err, input int ninit,
                      output int stall);
    exp_t x;
    stall = 0;
    desc_start = ADDRW'(s);
    desc_end   = ADDRW'(e);
    desc_tag   = TAGW'(t);
    desc_valid = 1'b1;
    while (!desc_ready && stall < 500) begin
      @(negedge clk);
      stall++;
    end
    if (!desc_ready) begin
      n_tot++;
      $display("FAIL push_timeout: got ready 0 want 1");
    end else begin
      x.s = ADDRW'(s);
      x.e = ADDRW'(e);
      x.tag = TAGW'(t);
      x.err = err;
      x.ninit = ninit;
      sbq.push_back(x);
    end
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_cpl(input int target);
    int g;
    g = 0;
    while (cpl_cnt < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cpl_cnt < target) begin
      n_tot++;
      $display("FAIL wait_cpl: got %0d want %0d", cpl_cnt, target);
    end
  endtask

  task automatic wait_start(output int at);
    int g;
    g = 0;
    while (!sm_start && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!sm_start) begin
      n_tot++;
      $display("FAIL wait_start: got 0 want 1");
    end
    at = cyc;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_init"}, 32'(sm_init), 0);
    chk({pfx, "_start"}, 32'(sm_start), 0);
    chk({pfx, "_addr"}, {sm_start_addr, sm_end_addr}, 0);
    chk({pfx, "_cpl"}, {cpl_valid, cpl_tag, cpl_err}, 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_jobs"}, 32'(jobs_done), 0);
    chk({pfx, "_ready"}, 32'(desc_ready), 1);
  endtask

  initial begin
    int st;
    int t0;
    int base;
    reset = 1'b0;
    desc_valid = 1'b0;
    desc_start = '0;
    desc_end = '0;
    desc_tag = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b1;
    @(negedge clk);

    // 1: single job, 20-cycle core
    core_lat = 20;
    push(2, 4, 3, 0, 1, st);
    wait_start(t0);
    repeat (10) @(negedge clk);
    chk("t1_hold", {sm_start_addr, sm_end_addr}, {8'd2, 8'd4});
    chk("t1_busy", 32'(busy), 1);
    wait_cpl(1);
    chk("t1_lat", last_cpl_cyc - t0, 21);
    repeat (3) @(negedge clk);

    // 2: six descriptors against a 4-deep FIFO
    core_lat = 5;
    gap_en = 1'b1;
    for (int i = 1; i <= 5; i++) push(i, i + 1, i, 0, 1, st);
    chk("t2_ready_full", 32'(desc_ready), 0);
    push(6, 7, 6, 0, 1, st);
    chk("t2_stalled", 32'(st > 0), 1);
    wait_cpl(7);
    gap_en = 1'b0;
    repeat (3) @(negedge clk);

    // 3: end < start is rejected without touching the core
    push(7, 3, 9, 1, 0, st);
    wait_cpl(8);
    repeat (3) @(negedge clk);

    // 4: done left high from the previous job
    push(1, 2, 10, 0, 1, st);
    wait_cpl(9);
    man_done = 1'b1;
    core_mode = 1;
    @(negedge clk);
    base = cpl_cnt;
    push(3, 4, 11, 0, 1, st);
    wait_start(t0);
    repeat (30) @(negedge clk);
    chk("t4_no_cpl", cpl_cnt, base);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    wait_cpl(base + 1);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    core_mode = 0;
    repeat (2) @(negedge clk);

    // 5: flush with 3 queued and one running
    core_lat = 30;
    base = cpl_cnt;
    push(5, 6, 12, 0, 1, st);
    wait_start(t0);
    push(1, 1, 13, 0, 1, st);
    push(2, 2, 14, 0, 1, st);
    push(3, 3, 15, 0, 1, st);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) void'(sbq.pop_back());
    chk("t5_ready", 32'(desc_ready), 1);
    wait_cpl(base + 1);
    repeat (5) @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cpls", cpl_cnt, base + 1);

    // 6: reset in BUSY
    core_mode = 2;
    push(8, 9, 5, 0, 1, st);
    wait_start(t0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk_reset_outs("mid");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = cpl_cnt;
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    push(8, 9, 5, 1, 1, st);
    wait_cpl(base + 1);
    base = cpl_cnt;
`endif
    core_mode = 0;
    core_lat = 4;
    push(1, 1, 6, 0, 1, st);
    wait_cpl(base + 1);
    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
